// File: rtl/iZero_pkg.sv
// Shared definitions for the iZero core: opcode/funct encodings,
// the fetch sequencer state encoding and small decode helpers.
package iZero_pkg;

  // Primary opcodes, instrucao[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_IN   = 6'b010011;
  localparam logic [5:0] OP_JF   = 6'b010101;
  localparam logic [5:0] OP_J    = 6'b010110;
  localparam logic [5:0] OP_JAL  = 6'b010111;
  localparam logic [5:0] OP_HALT = 6'b011000;

  // R-type function code, instrucao[5:0]
  localparam logic [5:0] FN_JR   = 6'b010010;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_IN = 2'd1,
    HALTED  = 2'd2,
    FAULT   = 2'd3
  } estado_t;

  // Extract the primary opcode field
  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  // Extract the R-type function field
  function automatic logic [5:0] get_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/proximo_pc.sv
// Purely combinational next-PC selection: sequential, j/jal, jr and jf.
// Halt/in handling lives in the sequencer; this block only answers
// "where would control go if this instruction retired now".
module proximo_pc
  import iZero_pkg::*;
#(
  parameter int PC_WIDTH = 26
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         instrucao,
  input  logic [31:0]         dado_rs,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [PC_WIDTH-1:0] pc_plus_one;

  assign opcode      = get_opcode(instrucao);
  assign funct       = get_funct(instrucao);
  // Sequential successor wraps naturally at 2^PC_WIDTH
  assign pc_plus_one = pc + PC_WIDTH'(1);

  // Next-PC mux keyed on opcode; jf falls through when rs is non-zero
  always_comb begin
    next_pc = pc_plus_one;
    unique case (opcode)
      OP_J, OP_JAL: next_pc = PC_WIDTH'(instrucao[25:0]);
      OP_JF: begin
        if (dado_rs == 32'd0) begin
          next_pc = PC_WIDTH'(instrucao[15:0]);
        end else begin
          next_pc = pc_plus_one;
        end
      end
      OP_R: begin
        if (funct == FN_JR) begin
          next_pc = dado_rs[PC_WIDTH-1:0];
        end else begin
          next_pc = pc_plus_one;
        end
      end
      default: next_pc = pc_plus_one;
    endcase
  end

endmodule

// File: rtl/contador_de_programa.sv
// Program counter / fetch sequencer for the single-cycle iZero core.
// Holds pc, stalls on "in" until the user supplies a value, and freezes
// on halt or on a fetch address outside the ROM.
//
// Handshake: entrada_valida is a single-cycle pulse with no ready side.
// It is consumed only while the sequencer is in WAIT_IN (commit rises in
// that same cycle); in any other state the pulse is dropped, never stored.
module contador_de_programa
  import iZero_pkg::*;
#(
  parameter int PC_WIDTH = 26,
  parameter int RESET_PC = 0,
  parameter int MEM_SIZE = 150
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instrucao,
  input  logic [31:0]         dado_rs,
  input  logic                entrada_valida,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_link,
  output logic                commit,
  output logic                aguardando_entrada,
  output logic                parado,
  output logic                erro_endereco
);

  localparam logic [PC_WIDTH-1:0] PC_RESET  = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] MEM_LIMIT = PC_WIDTH'(MEM_SIZE);

  estado_t             estado_q, estado_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                aguardando_q, aguardando_d;
  logic                parado_q, parado_d;
  logic                erro_q, erro_d;
  logic                commit_raw;
  logic [PC_WIDTH-1:0] next_pc;
  logic [5:0]          opcode;

  assign opcode = get_opcode(instrucao);

  proximo_pc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_proximo_pc (
    .pc        (pc_q),
    .instrucao (instrucao),
    .dado_rs   (dado_rs),
    .next_pc   (next_pc)
  );

  // Next state, next pc and retire decision for the current cycle
  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    commit_raw = 1'b0;
    unique case (estado_q)
      RUN: begin
        if (opcode == OP_HALT) begin
          commit_raw = 1'b1;
          estado_d   = HALTED;
        end else if (opcode == OP_IN) begin
          estado_d   = WAIT_IN;
        end else begin
          commit_raw = 1'b1;
          pc_d       = next_pc;
          // The offending address is still loaded so it can be inspected
          if (next_pc >= MEM_LIMIT) begin
            estado_d = FAULT;
          end
        end
      end
      WAIT_IN: begin
        if (entrada_valida) begin
          commit_raw = 1'b1;
          pc_d       = pc_q + PC_WIDTH'(1);
          estado_d   = RUN;
        end
      end
      HALTED:  estado_d = HALTED;
      FAULT:   estado_d = FAULT;
      default: estado_d = RUN;
    endcase
  end

  // Status flags decoded from the state being entered, so they are registered
  always_comb begin
    aguardando_d = (estado_d == WAIT_IN);
    parado_d     = (estado_d == HALTED) || (estado_d == FAULT);
    erro_d       = (estado_d == FAULT);
  end

  // Sequencer registers; reset overrides every state including a pending stall
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= RUN;
      pc_q         <= PC_RESET;
      aguardando_q <= 1'b0;
      parado_q     <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pc_q         <= pc_d;
      aguardando_q <= aguardando_d;
      parado_q     <= parado_d;
      erro_q       <= erro_d;
    end
  end

  // Output drive; commit is suppressed while reset is asserted so no write
  // can slip into the register file during a reset cycle
  always_comb begin
    pc                 = pc_q;
    pc_link            = pc_q + PC_WIDTH'(1);
    commit             = commit_raw & ~reset;
    aguardando_entrada = aguardando_q;
    parado             = parado_q;
    erro_endereco      = erro_q;
  end

endmodule

// File: tb/tb_contador_de_programa.sv
// Bench for contador_de_programa: directed vector table, hand-written
// boundary sequences and a randomized run against a behavioural model.
module tb_contador_de_programa;

  localparam int PCW = 26;
  localparam int MEMSZ = 150;

  logic            clock;
  logic            reset;
  logic [31:0]     instrucao;
  logic [31:0]     dado_rs;
  logic            entrada_valida;
  logic [PCW-1:0]  pc;
  logic [PCW-1:0]  pc_link;
  logic            commit;
  logic            aguardando_entrada;
  logic            parado;
  logic            erro_endereco;

  int checks;
  int errors;

  // sampled DUT values
  logic            a_commit;
  logic [PCW-1:0]  a_link;
  logic [PCW-1:0]  a_pc;
  logic            a_wait, a_parado, a_err;

  // scoreboard for expected pc in the random phase
  logic [PCW-1:0]  exp_q[$];

  contador_de_programa #(
    .PC_WIDTH (PCW),
    .RESET_PC (0),
    .MEM_SIZE (MEMSZ)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .instrucao          (instrucao),
    .dado_rs            (dado_rs),
    .entrada_valida     (entrada_valida),
    .pc                 (pc),
    .pc_link            (pc_link),
    .commit             (commit),
    .aguardando_entrada (aguardando_entrada),
    .parado             (parado),
    .erro_endereco      (erro_endereco)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // instruction builders
  function automatic logic [31:0] ins_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction
  function automatic logic [31:0] ins_jf(input logic [4:0] rs, input logic [15:0] imm);
    return {6'b010101, rs, 5'd0, imm};
  endfunction
  function automatic logic [31:0] ins_jr(input logic [4:0] rs);
    return {6'b000000, rs, 15'd0, 6'b010010};
  endfunction

  localparam logic [31:0] I_NOP  = 32'h2000_0000;
  localparam logic [31:0] I_IN   = 32'h4C00_0000;
  localparam logic [31:0] I_HALT = 32'h6000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // driver: inputs at negedge, combinational sample before the edge,
  // registered sample 1 time unit after the edge
  task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] rs, input logic ev);
    @(negedge clock);
    reset = rst;
    instrucao = ins;
    dado_rs = rs;
    entrada_valida = ev;
    #1;
    a_commit = commit;
    a_link = pc_link;
    @(posedge clock);
    #1;
    a_pc = pc;
    a_wait = aguardando_entrada;
    a_parado = parado;
    a_err = erro_endereco;
  endtask

  typedef struct {
    logic           rst;
    logic [31:0]    ins;
    logic [31:0]    rs;
    logic           ev;
    logic           e_commit;
    logic [PCW-1:0] e_link;
    logic [PCW-1:0] e_pc;
    logic           e_wait;
    logic           e_parado;
    logic           e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [31:0] ins, input logic [31:0] rs, input logic ev,
                     input logic ec, input int el, input int ep,
                     input logic ew, input logic epa, input logic ee);
    vec_t v;
    v.rst = rst; v.ins = ins; v.rs = rs; v.ev = ev;
    v.e_commit = ec; v.e_link = PCW'(el); v.e_pc = PCW'(ep);
    v.e_wait = ew; v.e_parado = epa; v.e_err = ee;
    tbl.push_back(v);
  endtask

  // behavioural reference state
  logic [PCW-1:0] m_pc;
  bit m_wait, m_halt, m_fault;

  // expected commit this cycle, and model advance across the edge
  task automatic model_step(input logic rst, input logic [31:0] ins, input logic [31:0] rs,
                            input logic ev, output logic e_commit);
    logic [5:0] op;
    logic [PCW-1:0] tgt;
    op = ins[31:26];
    e_commit = 1'b0;
    if (rst) begin
      m_pc = '0; m_wait = 0; m_halt = 0; m_fault = 0;
    end else if (m_halt || m_fault) begin
      e_commit = 1'b0;
    end else if (m_wait) begin
      if (ev) begin
        e_commit = 1'b1;
        m_pc = m_pc + 1;
        m_wait = 0;
      end
    end else if (op == 6'b011000) begin
      e_commit = 1'b1;
      m_halt = 1;
    end else if (op == 6'b010011) begin
      m_wait = 1;
    end else begin
      e_commit = 1'b1;
      tgt = m_pc + 1;
      if (op == 6'b010110 || op == 6'b010111) tgt = ins[25:0];
      else if (op == 6'b010101 && rs == 0) tgt = {10'd0, ins[15:0]};
      else if (op == 6'b000000 && ins[5:0] == 6'b010010) tgt = rs[PCW-1:0];
      m_pc = tgt;
      if (int'(tgt) >= MEMSZ) m_fault = 1;
    end
  endtask

  initial begin
    logic e_commit;
    logic [PCW-1:0] prev_pc;
    logic [PCW-1:0] epc;
    logic [31:0] ins, rs;
    logic rst, ev;
    int r;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    instrucao = I_NOP;
    dado_rs = '0;
    entrada_valida = 1'b0;
    repeat (2) @(posedge clock);

    // rst ins rs ev | commit link pc wait parado err
    add(1, I_NOP, 0, 0,                0, 1, 0, 0, 0, 0);
    add(0, ins_j(6'b010110, 30), 0, 0, 1, 1, 30, 0, 0, 0);
    add(0, ins_j(6'b010110, 35), 0, 0, 1, 31, 35, 0, 0, 0);
    add(0, ins_j(6'b010111, 1), 0, 0,  1, 36, 1, 0, 0, 0);
    add(0, ins_jr(5'd31), 36, 0,       1, 2, 36, 0, 0, 0);
    add(0, ins_jf(5'd3, 16'h1C), 0, 0, 1, 37, 28, 0, 0, 0);
    add(0, ins_j(6'b010110, 12), 0, 0, 1, 29, 12, 0, 0, 0);
    add(0, ins_jf(5'd3, 16'h1C), 5, 0, 1, 13, 13, 0, 0, 0);
    add(0, ins_j(6'b010110, 31), 0, 0, 1, 14, 31, 0, 0, 0);
    add(0, I_IN, 0, 0,                 0, 32, 31, 1, 0, 0);
    add(0, I_IN, 0, 0,                 0, 32, 31, 1, 0, 0);
    add(0, I_IN, 0, 0,                 0, 32, 31, 1, 0, 0);
    add(0, I_IN, 0, 1,                 1, 32, 32, 0, 0, 0);
    add(0, ins_j(6'b010110, 41), 0, 0, 1, 33, 41, 0, 0, 0);
    add(0, I_HALT, 0, 0,               1, 42, 41, 0, 1, 0);
    add(0, ins_j(6'b010110, 5), 0, 1,  0, 42, 41, 0, 1, 0);
    add(0, I_IN, 0, 1,                 0, 42, 41, 0, 1, 0);
    add(1, ins_j(6'b010110, 5), 0, 0,  0, 42, 0, 0, 0, 0);
    add(0, ins_j(6'b010110, 200), 0, 0, 1, 1, 200, 0, 1, 1);
    add(0, ins_j(6'b010110, 5), 0, 1,  0, 201, 200, 0, 1, 1);
    add(1, I_NOP, 0, 0,                0, 201, 0, 0, 0, 0);
    add(0, I_IN, 0, 0,                 0, 1, 0, 1, 0, 0);
    add(1, I_NOP, 0, 1,                0, 1, 0, 0, 0, 0);
    add(0, I_NOP, 0, 0,                1, 1, 1, 0, 0, 0);
    add(0, I_NOP, 0, 1,                1, 2, 2, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ins, tbl[i].rs, tbl[i].ev);
      check($sformatf("v%0d_commit", i), {31'd0, a_commit}, {31'd0, tbl[i].e_commit});
      check($sformatf("v%0d_pc_link", i), 32'(a_link), 32'(tbl[i].e_link));
      check($sformatf("v%0d_pc", i), 32'(a_pc), 32'(tbl[i].e_pc));
      check($sformatf("v%0d_wait", i), {31'd0, a_wait}, {31'd0, tbl[i].e_wait});
      check($sformatf("v%0d_parado", i), {31'd0, a_parado}, {31'd0, tbl[i].e_parado});
      check($sformatf("v%0d_err", i), {31'd0, a_err}, {31'd0, tbl[i].e_err});
    end

    // last valid word then first invalid one
    drive(0, ins_j(6'b010110, 149), 0, 0);
    check("edge149_pc", 32'(a_pc), 32'd149);
    check("edge149_err", {31'd0, a_err}, 32'd0);
    drive(0, I_NOP, 0, 0);
    check("edge150_commit", {31'd0, a_commit}, 32'd1);
    check("edge150_pc", 32'(a_pc), 32'd150);
    check("edge150_err", {31'd0, a_err}, 32'd1);
    check("edge150_parado", {31'd0, a_parado}, 32'd1);
    drive(1, I_NOP, 0, 0);
    check("rst_after_fault_pc", 32'(a_pc), 32'd0);
    // top of the address space: pc_link wraps to zero
    drive(0, ins_j(6'b010110, 26'h3FF_FFFF), 0, 0);
    check("top_pc", 32'(a_pc), 32'h3FF_FFFF);
    drive(0, I_NOP, 0, 1);
    check("top_link_wrap", 32'(a_link), 32'd0);
    check("top_frozen_pc", 32'(a_pc), 32'h3FF_FFFF);
    check("top_commit", {31'd0, a_commit}, 32'd0);

    // randomized run against the behavioural model
    drive(1, I_NOP, 0, 0);
    m_pc = '0; m_wait = 0; m_halt = 0; m_fault = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 19);
      case (r)
        0, 1, 2: ins = ins_j(6'b010110, 26'($urandom_range(0, 160)));
        3, 4:    ins = ins_j(6'b010111, 26'($urandom_range(0, 160)));
        5, 6, 7: ins = ins_jf(5'($urandom_range(0, 31)), 16'($urandom_range(0, 160)));
        8, 9:    ins = ins_jr(5'($urandom_range(0, 31)));
        10, 11:  ins = I_IN;
        12:      ins = I_HALT;
        default: begin
          ins = $urandom;
          if (ins[31:26] inside {6'b010110, 6'b010111, 6'b010101, 6'b010011, 6'b011000})
            ins[31:26] = 6'b000001;
        end
      endcase
      rs = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(0, 155));
      ev = ($urandom_range(0, 2) == 0);
      prev_pc = m_pc;
      model_step(rst, ins, rs, ev, e_commit);
      exp_q.push_back(m_pc);
      drive(rst, ins, rs, ev);
      check($sformatf("r%0d_commit", n), {31'd0, a_commit}, {31'd0, e_commit});
      check($sformatf("r%0d_link", n), 32'(a_link), 32'(prev_pc + PCW'(1)));
      epc = exp_q.pop_front();
      check($sformatf("r%0d_pc", n), 32'(a_pc), 32'(epc));
      check($sformatf("r%0d_wait", n), {31'd0, a_wait}, {31'd0, m_wait});
      check($sformatf("r%0d_parado", n), {31'd0, a_parado}, {31'd0, (m_halt | m_fault)});
      check($sformatf("r%0d_err", n), {31'd0, a_err}, {31'd0, m_fault});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
